reconfig_ro_chain: RTL and testbench

RECONFIG_RO_CHAIN -- requirements
Module: reconfig_ro_chain

---
 rtl/reconfig_ro_chain.sv | 126 ++++++++++++
 tb/tb_reconfig_ro_chain.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reconfig_ro_chain.sv
// Reconfigurable ring-oscillator stage chain with a shadow/active select pair and a safe update sequence.
// Optional macro CFG_READBACK_EN: swaps shadow with the old selects on update and drives cfg_so for readback.
module reconfig_ro_chain #(
    parameter int N_STAGES   = 4,
    parameter int SEL_W      = 2,
    parameter int SETTLE_CYC = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_si,
    input  logic                                cfg_shift,
    output logic                                cfg_so,
    input  logic                                commit_valid,
    output logic                                commit_ready,
    input  logic [N_STAGES*(2**SEL_W)-1:0]      stage_in,
    output logic [N_STAGES-1:0]                 stage_out,
    output logic                                ro_en,
    output logic [N_STAGES*SEL_W-1:0]           sel_active,
    output logic                                done
);

    localparam int NIN   = 2**SEL_W;
    localparam int TOT   = N_STAGES*SEL_W;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DISABLE = 3'd1,
        SETTLE  = 3'd2,
        LOAD    = 3'd3,
        ENABLE  = 3'd4
    } state_t;

    state_t             state_r;
    logic [TOT-1:0]     shadow_r;
    logic [TOT-1:0]     sel_active_r;
    logic [CNT_W-1:0]   settle_cnt_r;
    logic               ro_en_r;
    logic               done_r;
    logic               commit_ready_r;
    logic [TOT-1:0]     shift_next_s;
    logic               accept_s;

    // Next shadow value for one serial shift and the commit handshake.
    always_comb begin
        shift_next_s    = shadow_r << 1;
        shift_next_s[0] = cfg_si;
        accept_s        = commit_valid & commit_ready_r;
    end

    // Sequencer: the oscillator is stopped and allowed to settle before new selects are applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            shadow_r       <= {TOT{1'b0}};
            sel_active_r   <= {TOT{1'b0}};
            settle_cnt_r   <= {CNT_W{1'b0}};
            ro_en_r        <= 1'b0;
            done_r         <= 1'b0;
            commit_ready_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A commit wins over a coincident shift.
                    if (accept_s) begin
                        state_r        <= DISABLE;
                        ro_en_r        <= 1'b0;
                        commit_ready_r <= 1'b0;
                    end else if (cfg_shift) begin
                        shadow_r <= shift_next_s;
                    end
                end
                DISABLE: begin
                    state_r      <= SETTLE;
                    settle_cnt_r <= CNT_W'(SETTLE_CYC - 1);
                end
                SETTLE: begin
                    if (settle_cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= LOAD;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - CNT_W'(1);
                    end
                end
                LOAD: begin
                    state_r      <= ENABLE;
                    sel_active_r <= shadow_r;
`ifdef CFG_READBACK_EN
                    shadow_r     <= sel_active_r;
`endif
                end
                ENABLE: begin
                    state_r        <= IDLE;
                    ro_en_r        <= 1'b1;
                    done_r         <= 1'b1;
                    commit_ready_r <= 1'b1;
                end
                default: begin
                    state_r        <= IDLE;
                    ro_en_r        <= 1'b0;
                    settle_cnt_r   <= {CNT_W{1'b0}};
                    commit_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign commit_ready = commit_ready_r;
    assign ro_en        = ro_en_r;
    assign done         = done_r;
    assign sel_active   = sel_active_r;

`ifdef CFG_READBACK_EN
    assign cfg_so = shadow_r[TOT-1];
`else
    assign cfg_so = 1'b0;
`endif

    // Per-stage candidate mux driven by the active selects.
    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        logic [NIN-1:0] cand_s;
        assign cand_s       = stage_in[i*NIN +: NIN];
        assign stage_out[i] = cand_s[sel_active_r[i*SEL_W +: SEL_W]];
    end

endmodule

// File: tb/tb_reconfig_ro_chain.sv
// Directed self-checking bench for reconfig_ro_chain (N_STAGES=4, SEL_W=2, SETTLE_CYC=8).
module tb_reconfig_ro_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_si;
    logic        cfg_shift;
    logic        cfg_so;
    logic        commit_valid;
    logic        commit_ready;
    logic [15:0] stage_in;
    logic [3:0]  stage_out;
    logic        ro_en;
    logic [7:0]  sel_active;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    reconfig_ro_chain #(.N_STAGES(4), .SEL_W(2), .SETTLE_CYC(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_si       (cfg_si),
        .cfg_shift    (cfg_shift),
        .cfg_so       (cfg_so),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .stage_in     (stage_in),
        .stage_out    (stage_out),
        .ro_en        (ro_en),
        .sel_active   (sel_active),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] stim;
        logic [3:0]  exp;
    } mux_vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic shift_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            cfg_shift = 1'b1;
            cfg_si    = b[i];
            tick();
        end
        cfg_shift = 1'b0;
        cfg_si    = 1'b0;
    endtask

    // Accept one commit, optionally with a coincident shift and stray shift pulses while settling.
    task automatic do_commit(input bit shift_too, input int junk_shifts,
                             input logic [7:0] old_sel, output int lowcnt, output bit early);
        commit_valid = 1'b1;
        cfg_shift    = shift_too;
        cfg_si       = 1'b1;
        tick();
        commit_valid = 1'b0;
        cfg_shift    = 1'b0;
        lowcnt       = 0;
        early        = 1'b0;
        while (ro_en == 1'b0 && lowcnt < 50) begin
            if (lowcnt < 10 && sel_active !== old_sel) early = 1'b1;
            cfg_shift = (lowcnt >= 1 && lowcnt <= junk_shifts);
            cfg_si    = 1'b1;
            lowcnt++;
            tick();
        end
        cfg_shift = 1'b0;
        cfg_si    = 1'b0;
    endtask

    initial begin
        mux_vec_t vecs[10];
        int  lowcnt;
        bit  early;
        bit  bad_done;
        bit  bad_en;
        bit  bad_sel;
        logic [7:0] rb_exp;

        vecs[0] = '{16'hA5C3, 4'b1101};
        vecs[1] = '{16'h0000, 4'b0000};
        vecs[2] = '{16'hFFFF, 4'b1111};
        vecs[3] = '{16'h8421, 4'b1111};
        vecs[4] = '{16'h7BDE, 4'b0000};
        vecs[5] = '{16'h0001, 4'b0001};
        vecs[6] = '{16'h0020, 4'b0010};
        vecs[7] = '{16'h0400, 4'b0100};
        vecs[8] = '{16'h8000, 4'b1000};
        vecs[9] = '{16'h0002, 4'b0000};

        rst = 1'b1; cfg_si = 1'b0; cfg_shift = 1'b0; commit_valid = 1'b0; stage_in = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ro_en", ro_en, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sel", sel_active, 8'h00);
        check("reset_ready", commit_ready, 1'b1);
        check("reset_cfg_so", cfg_so, 1'b0);

        // First commit of 0xE4
        shift_byte(8'hE4);
        check("sel_before_commit", sel_active, 8'h00);
        do_commit(1'b0, 0, 8'h00, lowcnt, early);
        check("e4_low_cycles", lowcnt, 11);
        check("e4_sel_early", early, 1'b0);
        check("e4_sel", sel_active, 8'hE4);
        check("e4_done", done, 1'b1);
        check("e4_ready_in_done", commit_ready, 1'b1);
        tick();
        check("e4_done_one_cycle", done, 1'b0);
        check("e4_ro_en_stays", ro_en, 1'b1);

        // Mux table with sel_active = 0xE4
        for (int i = 0; i < 10; i++) begin
            stage_in = vecs[i].stim;
            #1;
            for (int b = 0; b < 4; b++) begin
                check($sformatf("mux_v%0d_stage%0d", i, b), stage_out[b], vecs[i].exp[b]);
            end
        end
        stage_in = 16'h0000;

        // Reset in the middle of the settle phase
        shift_byte(8'h1B);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_ro_en_low", ro_en, 1'b0);
        check("mid_ready_low", commit_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sel", sel_active, 8'h00);
        check("abort_ro_en", ro_en, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ready", commit_ready, 1'b1);
        bad_done = 1'b0; bad_en = 1'b0; bad_sel = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done !== 1'b0) bad_done = 1'b1;
            if (ro_en !== 1'b0) bad_en = 1'b1;
            if (sel_active !== 8'h00) bad_sel = 1'b1;
        end
        check("abort_no_done", bad_done, 1'b0);
        check("abort_osc_off", bad_en, 1'b0);
        check("abort_sel_hold", bad_sel, 1'b0);

        // Commit coinciding with a shift, plus stray shifts while settling
        shift_byte(8'h3C);
        do_commit(1'b1, 3, 8'h00, lowcnt, early);
        check("collide_low_cycles", lowcnt, 11);
        check("collide_sel_early", early, 1'b0);
        check("collide_sel", sel_active, 8'h3C);
        check("collide_done", done, 1'b1);
        tick();

        // commit_valid held high: back-to-back reconfigurations every 12 cycles
        commit_valid = 1'b1;
        for (int t = 1; t <= 36; t++) begin
            tick();
            check($sformatf("b2b_ro_en_t%0d", t), ro_en, (t % 12 == 0));
            check($sformatf("b2b_done_t%0d", t), done, (t % 12 == 0));
            check($sformatf("b2b_ready_t%0d", t), commit_ready, (t % 12 == 0));
            if (t == 36) commit_valid = 1'b0;
        end
        tick();
        check("b2b_idle_after", commit_ready, 1'b1);
        check("b2b_ro_en_after", ro_en, 1'b1);
        check("b2b_done_after", done, 1'b0);

        // Readback: commit 0xE4 then 0x1B, then shift the shadow out
        rst = 1'b1;
        tick();
        rst = 1'b0;
        shift_byte(8'hE4);
        do_commit(1'b0, 0, 8'h00, lowcnt, early);
        check("rb_first_sel", sel_active, 8'hE4);
        tick();
        shift_byte(8'h1B);
        do_commit(1'b0, 0, 8'hE4, lowcnt, early);
        check("rb_second_low", lowcnt, 11);
        check("rb_second_sel", sel_active, 8'h1B);
        tick();
`ifdef CFG_READBACK_EN
        rb_exp = 8'hE4;
`else
        rb_exp = 8'h00;
`endif
        for (int i = 7; i >= 0; i--) begin
            check($sformatf("rb_cfg_so_bit%0d", 7 - i), cfg_so, rb_exp[i]);
            cfg_shift = 1'b1;
            cfg_si    = 1'b0;
            tick();
        end
        cfg_shift = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
